// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types plus the enums and records used by the RAM request arbiter.
// Optional statistics are enabled with the ARB_STATS_EN macro.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic core;
        logic is_data;
        logic write;
    } arb_sel_t;

    localparam int ARB_NREQ = 4;

    // Flat requester index {core, is_data} used by the per-requester grant counters.
    function automatic logic [1:0] arb_req_idx(arb_sel_t s);
        return {s.core, s.is_data};
    endfunction

endpackage

// File: rtl/ram_request_arbiter_if.sv
// Request/grant bundle between the cache request lines, memory_control and the arbiter.
// Handshake: a grant stays valid until the RAM reports ACCESS (or the requester drops its line).
interface ram_request_arbiter_if;
    import cpu_types_pkg::*;

    logic [1:0] iREN;
    logic [1:0] dREN;
    logic [1:0] dWEN;
    logic       coh_busy;
    ramstate_t  ramstate;

    logic       grant_valid;
    logic       grant_core;
    logic       grant_is_data;
    logic       grant_write;
    logic       xfer_done;
    logic       starve_fire;

    modport slave (
        input  iREN, dREN, dWEN, coh_busy, ramstate,
        output grant_valid, grant_core, grant_is_data, grant_write, xfer_done, starve_fire
    );

    modport master (
        output iREN, dREN, dWEN, coh_busy, ramstate,
        input  grant_valid, grant_core, grant_is_data, grant_write, xfer_done, starve_fire
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// Per-core saturating count of data grants taken while that core's instruction fetch waits.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_limit = (cnt == W'(LIMIT));

endmodule

// File: rtl/ram_request_arbiter.sv
// Shares the single RAM port among icache0/dcache0/icache1/dcache1 with round-robin cores.
// Define ARB_STATS_EN to add the per-requester grant_cnt counters.
module ram_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CPUS         = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    ram_request_arbiter_if.slave   arb,
    output arb_state_t             dbg_state
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]            grant_cnt [ARB_NREQ]
`endif
);

    if (CPUS != 2) begin : g_cpus_check
        $error("ram_request_arbiter supports exactly two cores");
    end

    arb_state_t state, state_d;
    arb_sel_t   sel_q;
    logic       grant_valid_q;
    logic       starve_fire_q;
    logic       rr_ptr;

    arb_sel_t   pick [2];
    logic [1:0] pick_starve;
    logic [1:0] has_req;
    logic [1:0] at_limit;
    logic [1:0] starve_inc;
    logic [1:0] starve_clr;
    logic       win;
    arb_sel_t   win_sel;
    logic       granted_bit;
    logic       issue;
    logic       done;
    logic       abort;

    // Per-core candidate: a starving fetch first, then write, read, fetch.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            has_req[c]         = arb.iREN[c] | arb.dREN[c] | arb.dWEN[c];
            pick_starve[c]     = 1'b0;
            pick[c].core       = 1'(c);
            pick[c].is_data    = 1'b0;
            pick[c].write      = 1'b0;
            if (at_limit[c] && arb.iREN[c]) begin
                pick_starve[c] = 1'b1;
            end else if (arb.dWEN[c]) begin
                pick[c].is_data = 1'b1;
                pick[c].write   = 1'b1;
            end else if (arb.dREN[c]) begin
                pick[c].is_data = 1'b1;
            end
        end
    end

    assign win     = has_req[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign win_sel = pick[win];

    assign granted_bit = sel_q.is_data ? (sel_q.write ? arb.dWEN[sel_q.core] : arb.dREN[sel_q.core])
                                       : arb.iREN[sel_q.core];

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!arb.coh_busy && (|has_req)) begin
                    issue   = 1'b1;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (arb.ramstate == ACCESS) begin
                    done    = 1'b1;
                    state_d = ARB_IDLE;
                end else if (!granted_bit) begin
                    abort   = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= ARB_IDLE;
            sel_q         <= '0;
            grant_valid_q <= 1'b0;
            starve_fire_q <= 1'b0;
            rr_ptr        <= 1'b0;
        end else begin
            state         <= state_d;
            starve_fire_q <= 1'b0;
            if (issue) begin
                sel_q         <= win_sel;
                grant_valid_q <= 1'b1;
                starve_fire_q <= pick_starve[win];
            end else if (done || abort) begin
                grant_valid_q <= 1'b0;
            end
            // An aborted grant leaves priority where it was.
            if (done) begin
                rr_ptr <= ~sel_q.core;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            starve_inc[c] = issue && (win == 1'(c)) && win_sel.is_data && arb.iREN[c];
            starve_clr[c] = !arb.iREN[c] || (issue && (win == 1'(c)) && !win_sel.is_data);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_starve
        arb_starve_ctr #(
            .LIMIT(STARVE_LIMIT)
        ) u_ctr (
            .CLK     (CLK),
            .nRST    (nRST),
            .inc     (starve_inc[g]),
            .clr     (starve_clr[g]),
            .at_limit(at_limit[g])
        );
    end

    assign arb.grant_valid   = grant_valid_q;
    assign arb.grant_core    = sel_q.core;
    assign arb.grant_is_data = sel_q.is_data;
    assign arb.grant_write   = sel_q.write;
    assign arb.starve_fire   = starve_fire_q;
    assign arb.xfer_done     = grant_valid_q && (arb.ramstate == ACCESS);
    assign dbg_state         = state;

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ARB_NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (arb.xfer_done) begin
            grant_cnt[arb_req_idx(sel_q)] <= grant_cnt[arb_req_idx(sel_q)] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Self-checking bench for ram_request_arbiter: decision table, corner sequences, random vs model.
module tb_ram_request_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    ram_request_arbiter_if bus();
    arb_state_t dbg_state;
`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt [ARB_NREQ];
`endif

    ram_request_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .CPUS        (2)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .arb      (bus),
        .dbg_state(dbg_state)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iREN     = 2'b00;
        bus.dREN     = 2'b00;
        bus.dWEN     = 2'b00;
        bus.coh_busy = 1'b0;
        bus.ramstate = FREE;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int core;
        int data;
        int write;
        int fire;
    } cand_t;

    int m_valid, m_core, m_data, m_write, m_fire, m_rr;
    int m_cnt [2];
    logic [3:0] exp_q [$];

    function automatic void model_reset();
        m_valid = 0; m_core = 0; m_data = 0; m_write = 0; m_fire = 0; m_rr = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        exp_q.delete();
    endfunction

    // One clock edge: ranked candidate list built from the priority rules; head wins.
    function automatic void model_step();
        int iren [2];
        int dren [2];
        int dwen [2];
        int still;
        cand_t cands [$];
        cand_t w;
        for (int c = 0; c < 2; c++) begin
            iren[c] = int'(bus.iREN[c]);
            dren[c] = int'(bus.dREN[c]);
            dwen[c] = int'(bus.dWEN[c]);
        end
        m_fire = 0;
        if (m_valid == 0) begin
            if (!bus.coh_busy) begin
                for (int k = 0; k < 2; k++) begin
                    int c;
                    c = (k == 0) ? m_rr : 1 - m_rr;
                    if (m_cnt[c] == LIMIT && iren[c] != 0) cands.push_back('{c, 0, 0, 1});
                    if (dwen[c] != 0) cands.push_back('{c, 1, 1, 0});
                    if (dren[c] != 0) cands.push_back('{c, 1, 0, 0});
                    if (iren[c] != 0) cands.push_back('{c, 0, 0, 0});
                end
                if (cands.size() > 0) begin
                    w = cands[0];
                    m_valid = 1; m_core = w.core; m_data = w.data; m_write = w.write; m_fire = w.fire;
                    exp_q.push_back({w.core[0], w.data[0], w.write[0], w.fire[0]});
                    if (w.data != 0 && iren[w.core] != 0)
                        m_cnt[w.core] = (m_cnt[w.core] + 1 > LIMIT) ? LIMIT : m_cnt[w.core] + 1;
                    if (w.data == 0) m_cnt[w.core] = 0;
                end
            end
        end else if (bus.ramstate == ACCESS) begin
            m_valid = 0;
            m_rr = 1 - m_core;
        end else begin
            still = (m_data != 0) ? ((m_write != 0) ? dwen[m_core] : dren[m_core]) : iren[m_core];
            if (still == 0) m_valid = 0;
        end
        for (int c = 0; c < 2; c++) if (iren[c] == 0) m_cnt[c] = 0;
    endfunction

    task automatic rand_inputs(input int iren_odds);
        for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, iren_odds - 1) == 0) bus.iREN[c] = ~bus.iREN[c];
            if ($urandom_range(0, 3) == 0) bus.dREN[c] = ~bus.dREN[c];
            if ($urandom_range(0, 5) == 0) bus.dWEN[c] = ~bus.dWEN[c];
        end
        bus.coh_busy = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 5))
            0:       bus.ramstate = FREE;
            1, 2:    bus.ramstate = BUSY;
            3, 4:    bus.ramstate = ACCESS;
            default: bus.ramstate = ERROR;
        endcase
    endtask

    // ---------------- decision table ----------------
    typedef struct {
        string      name;
        logic [1:0] iren;
        logic [1:0] dren;
        logic [1:0] dwen;
        logic       coh;
        logic       ev;
        logic       ec;
        logic       ed;
        logic       ew;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic prev_valid;
        logic [3:0] rec;

        vecs[0]  = '{"no_req",        2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"i0_only",       2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"i1_only",       2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"d_both",        2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{"w1_only",       2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{"c0_all",        2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{"i0_vs_d1",      2'b01, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"d0_vs_i1",      2'b10, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{"coh_block",     2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"d0_w1",         2'b11, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{"c1_i_and_d",    2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{"w_both",        2'b00, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset values while nRST is held low.
        clear_inputs();
        nRST = 1'b0;
        tick();
        chk("rst_valid",   32'(bus.grant_valid), 0);
        chk("rst_core",    32'(bus.grant_core), 0);
        chk("rst_is_data", 32'(bus.grant_is_data), 0);
        chk("rst_write",   32'(bus.grant_write), 0);
        chk("rst_fire",    32'(bus.starve_fire), 0);
        chk("rst_xfer",    32'(bus.xfer_done), 0);
        chk("rst_state",   32'(dbg_state), 32'(ARB_IDLE));

        for (int v = 0; v < 12; v++) begin
            do_reset();
            bus.iREN = vecs[v].iren;
            bus.dREN = vecs[v].dren;
            bus.dWEN = vecs[v].dwen;
            bus.coh_busy = vecs[v].coh;
            tick();
            chk({vecs[v].name, "_valid"},   32'(bus.grant_valid),   32'(vecs[v].ev));
            chk({vecs[v].name, "_core"},    32'(bus.grant_core),    32'(vecs[v].ec));
            chk({vecs[v].name, "_is_data"}, 32'(bus.grant_is_data), 32'(vecs[v].ed));
            chk({vecs[v].name, "_write"},   32'(bus.grant_write),   32'(vecs[v].ew));
        end

        // Asynchronous reset in the middle of a held grant.
        do_reset();
        bus.dWEN = 2'b10;
        bus.ramstate = BUSY;
        tick();
        chk("mid_pre_valid", 32'(bus.grant_valid), 1);
        chk("mid_pre_core",  32'(bus.grant_core), 1);
        #3;
        bus.ramstate = ACCESS;
        nRST = 1'b0;
        #1;
        chk("mid_rst_valid",   32'(bus.grant_valid), 0);
        chk("mid_rst_core",    32'(bus.grant_core), 0);
        chk("mid_rst_is_data", 32'(bus.grant_is_data), 0);
        chk("mid_rst_write",   32'(bus.grant_write), 0);
        chk("mid_rst_xfer",    32'(bus.xfer_done), 0);
        clear_inputs();
        bus.iREN = 2'b10;
        tick();
        chk("mid_hold_valid", 32'(bus.grant_valid), 0);
        nRST = 1'b1;
        tick();
        chk("mid_after_valid",   32'(bus.grant_valid), 1);
        chk("mid_after_core",    32'(bus.grant_core), 1);
        chk("mid_after_is_data", 32'(bus.grant_is_data), 0);

        // Both dcaches: core 0 first, then ACCESS rotates to core 1.
        do_reset();
        bus.dREN = 2'b11;
        tick();
        chk("rr_first_core", 32'(bus.grant_core), 0);
        chk("rr_first_data", 32'(bus.grant_is_data), 1);
        bus.ramstate = ACCESS;
        #1;
        chk("rr_xfer", 32'(bus.xfer_done), 1);
        tick();
        bus.ramstate = FREE;
        chk("rr_bubble", 32'(bus.grant_valid), 0);
        tick();
        chk("rr_second_valid", 32'(bus.grant_valid), 1);
        chk("rr_second_core",  32'(bus.grant_core), 1);

        // Starvation: four data grants, then the waiting fetch is forced ahead.
        do_reset();
        bus.iREN = 2'b01;
        bus.dREN = 2'b01;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk("starve_valid",   32'(bus.grant_valid), 1);
            chk("starve_is_data", 32'(bus.grant_is_data), (g == 4) ? 0 : 1);
            chk("starve_fire",    32'(bus.starve_fire), (g == 4) ? 1 : 0);
            if (g == 4) begin
                bus.ramstate = BUSY;
                tick();
                chk("starve_pulse", 32'(bus.starve_fire), 0);
                chk("starve_held",  32'(bus.grant_valid), 1);
            end
            bus.ramstate = ACCESS;
            tick();
            chk("starve_release", 32'(bus.grant_valid), 0);
            bus.ramstate = FREE;
        end

        // Abort: granted read drops before ACCESS; priority stays on core 0.
        do_reset();
        bus.dREN = 2'b01;
        bus.ramstate = BUSY;
        tick();
        chk("abort_grant", 32'(bus.grant_valid), 1);
        bus.dREN = 2'b00;
        #1;
        chk("abort_xfer", 32'(bus.xfer_done), 0);
        tick();
        chk("abort_valid", 32'(bus.grant_valid), 0);
        bus.dREN = 2'b11;
        tick();
        chk("abort_rr_valid", 32'(bus.grant_valid), 1);
        chk("abort_rr_core",  32'(bus.grant_core), 0);

        // coh_busy blocks new grants but never revokes one; ERROR holds.
        do_reset();
        bus.coh_busy = 1'b1;
        bus.iREN = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("coh_blocked", 32'(bus.grant_valid), 0);
        end
        bus.coh_busy = 1'b0;
        tick();
        chk("coh_grant_valid", 32'(bus.grant_valid), 1);
        chk("coh_grant_data",  32'(bus.grant_is_data), 0);
        bus.coh_busy = 1'b1;
        bus.ramstate = ERROR;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("err_hold_valid", 32'(bus.grant_valid), 1);
            chk("err_hold_xfer",  32'(bus.xfer_done), 0);
        end
        bus.ramstate = ACCESS;
        #1;
        chk("coh_xfer", 32'(bus.xfer_done), 1);
        tick();
        bus.ramstate = FREE;
        chk("coh_release", 32'(bus.grant_valid), 0);
        tick();
        chk("coh_reblock", 32'(bus.grant_valid), 0);

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        prev_valid = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rand_inputs((n < 1500) ? 16 : 64);
            #1;
            chk("rnd_xfer", 32'(bus.xfer_done), 32'(m_valid != 0 && bus.ramstate == ACCESS));
            @(posedge CLK);
            model_step();
            #1;
            chk("rnd_valid", 32'(bus.grant_valid), 32'(m_valid));
            chk("rnd_fire",  32'(bus.starve_fire), 32'(m_fire));
            if (m_valid != 0) begin
                chk("rnd_core",  32'(bus.grant_core), 32'(m_core));
                chk("rnd_data",  32'(bus.grant_is_data), 32'(m_data));
                chk("rnd_write", 32'(bus.grant_write), 32'(m_write));
            end
            if (bus.grant_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rnd_grant_rec: grant seen with no expected grant queued at %0t", $time);
                end else begin
                    rec = exp_q.pop_front();
                    chk("rnd_grant_rec",
                        32'({bus.grant_core, bus.grant_is_data, bus.grant_write, bus.starve_fire}),
                        32'(rec));
                end
            end
            prev_valid = bus.grant_valid;
        end
        chk("rnd_queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
